// File: rtl/fp19_acc.sv
// ============================================================================
// fp19_acc : grouped accumulator for 19-bit float products (1/8/10). Rev 1.0
// ============================================================================
`default_nettype none

module fp19_acc #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [18:0]      in_data,
  input  logic             in_exc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [18:0]      out_data,
  output logic             out_exc,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [18:0]      acc_q, acc_d;
  logic [18:0]      term_q, term_d;
  logic             texc_q, texc_d;
  logic             last_q, last_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [12:0]      big_q, big_d;
  logic [12:0]      small_q, small_d;
  logic             sign_q, sign_d;
  logic             sub_q, sub_d;
  logic [8:0]       exp_q, exp_d;
  logic [13:0]      sum_q, sum_d;
  logic             zero_q, zero_d;

  // Operand ordering and alignment: significands carry {sig[10:0], guard, sticky}.
  logic        acc_is_big;
  logic [18:0] big_op, small_op;
  logic [10:0] big_sig, small_sig;
  logic [7:0]  exp_diff;
  logic [22:0] shift_wide;
  logic [12:0] small_aligned;

  assign acc_is_big    = (acc_q[17:0] >= term_q[17:0]);
  assign big_op        = acc_is_big ? acc_q : term_q;
  assign small_op      = acc_is_big ? term_q : acc_q;
  assign big_sig       = {|big_op[17:10], big_op[9:0]};
  assign small_sig     = {|small_op[17:10], small_op[9:0]};
  assign exp_diff      = big_op[17:10] - small_op[17:10];
  assign shift_wide    = {small_sig, 12'd0} >> exp_diff;
  assign small_aligned = (exp_diff > 8'd12) ? {12'd0, |small_sig}
                                            : {shift_wide[22:11], |shift_wide[10:0]};

  // Round up only when both guard and sticky are set.
  logic [10:0] rnd_mant;
  logic [8:0]  rnd_exp;

  assign rnd_mant = {1'b0, sum_q[11:2]} + {10'd0, sum_q[1] & sum_q[0]};
  assign rnd_exp  = exp_q + {8'd0, rnd_mant[10]};

  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign out_valid = (state_q == S_OUT);
  assign out_data  = acc_q;
  assign out_exc   = sticky_q;
  assign out_count = cnt_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    term_d   = term_q;
    texc_d   = texc_q;
    last_d   = last_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    big_d    = big_q;
    small_d  = small_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    exp_d    = exp_q;
    sum_d    = sum_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          term_d  = in_data;
          texc_d  = in_exc | (&in_data[17:10]);
          last_d  = in_last;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = S_ALIGN;
          if (in_exc || (&in_data[17:10])) sticky_d = 1'b1;
        end
      end
      S_ALIGN: begin
        big_d   = {big_sig, 2'b00};
        small_d = small_aligned;
        sign_d  = big_op[18];
        sub_d   = big_op[18] ^ small_op[18];
        exp_d   = {1'b0, big_op[17:10]};
        state_d = S_ADD;
      end
      S_ADD: begin
        sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                        : ({1'b0, big_q} + {1'b0, small_q});
        zero_d  = 1'b0;
        state_d = S_NORM;
      end
      S_NORM: begin
        if (sum_q == 14'd0) begin
          zero_d  = 1'b1;
          state_d = S_ROUND;
        end else if (sum_q[13]) begin
          sum_d   = {1'b0, sum_q[13:3], sum_q[2], sum_q[1] | sum_q[0]};
          exp_d   = exp_q + 9'd1;
          state_d = S_ROUND;
        end else if (sum_q[12]) begin
          state_d = S_ROUND;
        end else if (exp_q <= 9'd1) begin
          // Underflow flushes silently to +0.
          zero_d  = 1'b1;
          state_d = S_ROUND;
        end else begin
          sum_d = {sum_q[12:0], 1'b0};
          exp_d = exp_q - 9'd1;
        end
      end
      S_ROUND: begin
        if (!texc_q) begin
          if (zero_q) begin
            acc_d = 19'd0;
          end else if (rnd_exp >= 9'd255) begin
            acc_d    = {sign_q, 18'd0};
            sticky_d = 1'b1;
          end else begin
            acc_d = {sign_q, rnd_exp[7:0], rnd_mant[9:0]};
          end
        end
        state_d = last_q ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        if (out_ready) begin
          acc_d    = 19'd0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= 19'd0;
      term_q   <= 19'd0;
      texc_q   <= 1'b0;
      last_q   <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      big_q    <= 13'd0;
      small_q  <= 13'd0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      exp_q    <= 9'd0;
      sum_q    <= 14'd0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      term_q   <= term_d;
      texc_q   <= texc_d;
      last_q   <= last_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      big_q    <= big_d;
      small_q  <= small_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      exp_q    <= exp_d;
      sum_q    <= sum_d;
      zero_q   <= zero_d;
    end
  end

endmodule

`default_nettype wire
